rinsc_pipe_ctrl: RTL and testbench
==================================

# rinsc_pipe_ctrl

Decode-stage controller for the RINSC 32-bit five-stage pipeline (IF, ID, EX, MEM, WB). It decodes the 8-bit opcode held in the IF/ID register into the datapath control word. It tracks in-flight register writes in a three-entry scoreboard and stalls decode on read-after-write hazards, since the datapath has no forwarding. It also flushes the wrong-path fetch slot after a jump.

## Interface
Parameters:
- `NSTAGE`, default 3: scoreboard depth (EX, MEM, WB); fixed by the pipeline.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high.
- `Op`, input, 8: IF/ID instruction bits [7:0].
- `Rs1`, input, 5: IF/ID bits [26:22].
- `Rs2`, input, 5: IF/ID bits [21:17].
- `Rd`, input, 5: IF/ID bits [31:27].
- `ALUOp`, output, 4: ALU function.
- `ALUSrc`, output, 2: ALU operand-b select. 00 = db, 01 = sign-extended immediate, 10 = shamt.
- `MemToReg`, output, 2: write-back select. 00 = memory, 01 = ALU, 10 = PC+4.
- `MemRead`, output, 1: load enable.
- `MemWrite`, output, 1: store enable.
- `RegWrite`, output, 1: register-file write enable.
- `PCSrc`, output, 1: take the jump target.
- `Stall`, output, 1: hold PC and IF/ID; a bubble enters ID/EX.
- `Flush`, output, 1: the current IF/ID content is wrong-path and is discarded.
- `Illegal`, output, 1: undefined opcode present in ID.

## Operation
- Opcode map:
  - 0x00 NOP: all controls 0.
  - 0x01–0x09 ADD, SUB, MUL, XOR, OR, AND, SLL, SRA, SRL: ALUOp = Op−1, ALUSrc 00, MemToReg 01, RegWrite 1. Sources Rs1 and Rs2.
  - 0x11–0x16 ADDI … ANDI: ALUOp = Op−0x11, ALUSrc 01, MemToReg 01, RegWrite 1. Source Rs1.
  - 0x17–0x19 SLLI, SRAI, SRLI: ALUOp 6/7/8, ALUSrc 10, MemToReg 01, RegWrite 1. Source Rs1.
  - 0x20 LW: ALUOp 0, ALUSrc 01, MemRead 1, MemToReg 00, RegWrite 1. Source Rs1.
  - 0x21 SW: ALUOp 0, ALUSrc 01, MemWrite 1. Sources Rs1 and Rs2.
  - 0x30 J: PCSrc 1. No sources.
  - 0x31 JAL: PCSrc 1, MemToReg 10, RegWrite 1. No sources.
  - Any other value: treated as NOP, with Illegal = 1 while it is present.
- Scoreboard: entries `sb[0..2]`, each `{valid, rd}`, tracking the EX, MEM and WB stages. Every cycle:
  - `sb[2]` ← `sb[1]`, `sb[1]` ← `sb[0]`.
  - `sb[0]` ← `{RegWrite_out, Rd}`. Entry 0 is therefore invalid whenever a bubble is issued.
- Hazard: a used source equals the `rd` of any valid entry. Register 0 is not special; it is compared like every other register.
- FSM states:
  - RUN: decode is normal. A hazard moves to STALL. A jump (PCSrc = 1) moves to FLUSH.
  - STALL: `Stall` = 1 and all control outputs are 0 (bubble). Returns to RUN when the hazard clears. The hazard condition is re-evaluated combinationally every cycle.
  - FLUSH: `Flush` = 1 for exactly one cycle. Controls are 0, no hazard check is made, and `Illegal` is 0. The state then returns to RUN.
- Jumps are never stalled, because J and JAL have no sources. A jump that immediately follows a jump cannot occur, since the second jump is in the flushed slot.

## Timing
- Control outputs, `Stall` and `Illegal` are combinational from `Op`, `Rs1`, `Rs2`, `Rd`, the FSM state and the scoreboard. They are captured by the datapath at the next edge.
- `Flush` is registered and is high in the cycle after the jump decodes.
- Stall length after a producer is 3, 2 or 1 cycles when the consumer immediately follows it, or follows it by 1 or 2 instructions. The consumer issues in the cycle after the producer leaves WB, because the register file is written at the WB edge and read combinationally.
- While `reset` is high:
  - the FSM is in RUN;
  - the scoreboard is cleared;
  - all outputs are 0, including `Illegal`.
- If reset is asserted during STALL or FLUSH, the block returns to RUN with an empty scoreboard in the first cycle after deassertion.

## Configuration
- `RINSC_HAZARD_STALL_EN` defined: scoreboard, STALL state and `Stall` output behave as specified.
- `RINSC_HAZARD_STALL_EN` undefined:
  - no scoreboard logic is built;
  - `Stall` is tied to 0;
  - software must insert NOPs between dependent instructions;
  - decode and FLUSH behaviour are unchanged.

## Structure
- Package `rinsc_pkg` holds:
  - opcode localparams (`OP_ADD` …);
  - ALUOp and ALUSrc/MemToReg encodings;
  - a packed `ctrl_t` struct containing the seven control fields.
- Sub-module `rinsc_scoreboard` holds the shift register and the hazard compare. Its inputs are the push entry, Rs1/Rs2 and their use flags; its output is `hazard`.

## Test plan
- ADDI r3 followed by ADD r4,r3,r5: `Stall` is high for 3 cycles, ADD issues on cycle 4, and r4 equals the new r3 plus r5.
- ADDI r3, NOP, NOP, ADD r4,r3,r3: `Stall` is high for exactly 1 cycle.
- ADD r1,r2,r3 followed by ADD r4,r5,r6: no stall; the controls for each instruction appear in consecutive cycles.
- J 0x40 at PC 0x08:
  - `PCSrc` = 1 for one cycle;
  - the next cycle has `Flush` = 1 with zero controls;
  - the instruction at 0x0C never writes;
  - fetch resumes at 0x40.
- LW r7 then SW r7: a 3-cycle stall, after which `MemWrite` is 1 and `MemRead` is 0.
- `reset` asserted during the second stall cycle: all outputs are 0. After release, the same ADD issues with no stall because the scoreboard is cleared.
- Op 0xFF: `Illegal` = 1 and all controls are 0 for that cycle; the scoreboard entry is invalid.

Source files
------------

// File: rtl/rinsc_pkg.sv
// Shared opcode map, control-word encodings and decode function for the RINSC decode-stage controller.
package rinsc_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_OR   = 8'h05;
    localparam logic [7:0] OP_AND  = 8'h06;
    localparam logic [7:0] OP_SLL  = 8'h07;
    localparam logic [7:0] OP_SRA  = 8'h08;
    localparam logic [7:0] OP_SRL  = 8'h09;
    localparam logic [7:0] OP_ADDI = 8'h11;
    localparam logic [7:0] OP_SUBI = 8'h12;
    localparam logic [7:0] OP_MULI = 8'h13;
    localparam logic [7:0] OP_XORI = 8'h14;
    localparam logic [7:0] OP_ORI  = 8'h15;
    localparam logic [7:0] OP_ANDI = 8'h16;
    localparam logic [7:0] OP_SLLI = 8'h17;
    localparam logic [7:0] OP_SRAI = 8'h18;
    localparam logic [7:0] OP_SRLI = 8'h19;
    localparam logic [7:0] OP_LW   = 8'h20;
    localparam logic [7:0] OP_SW   = 8'h21;
    localparam logic [7:0] OP_J    = 8'h30;
    localparam logic [7:0] OP_JAL  = 8'h31;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;

    localparam logic [1:0] SRC_DB    = 2'b00;
    localparam logic [1:0] SRC_IMM   = 2'b01;
    localparam logic [1:0] SRC_SHAMT = 2'b10;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic [1:0] mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_src;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  use_rs1;
        logic  use_rs2;
        logic  illegal;
    } dec_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic dec_t decode(input logic [7:0] op);
        dec_t d;
        d = '0;
        if (op >= OP_ADD && op <= OP_SRL) begin
            d.ctrl.alu_op     = 4'(op - OP_ADD);
            d.ctrl.alu_src    = SRC_DB;
            d.ctrl.mem_to_reg = WB_ALU;
            d.ctrl.reg_write  = 1'b1;
            d.use_rs1         = 1'b1;
            d.use_rs2         = 1'b1;
        end else if (op >= OP_ADDI && op <= OP_ANDI) begin
            d.ctrl.alu_op     = 4'(op - OP_ADDI);
            d.ctrl.alu_src    = SRC_IMM;
            d.ctrl.mem_to_reg = WB_ALU;
            d.ctrl.reg_write  = 1'b1;
            d.use_rs1         = 1'b1;
        end else if (op >= OP_SLLI && op <= OP_SRLI) begin
            d.ctrl.alu_op     = ALU_SLL + 4'(op - OP_SLLI);
            d.ctrl.alu_src    = SRC_SHAMT;
            d.ctrl.mem_to_reg = WB_ALU;
            d.ctrl.reg_write  = 1'b1;
            d.use_rs1         = 1'b1;
        end else begin
            case (op)
                OP_NOP: ;
                OP_LW: begin
                    d.ctrl.alu_op     = ALU_ADD;
                    d.ctrl.alu_src    = SRC_IMM;
                    d.ctrl.mem_read   = 1'b1;
                    d.ctrl.mem_to_reg = WB_MEM;
                    d.ctrl.reg_write  = 1'b1;
                    d.use_rs1         = 1'b1;
                end
                OP_SW: begin
                    d.ctrl.alu_op    = ALU_ADD;
                    d.ctrl.alu_src   = SRC_IMM;
                    d.ctrl.mem_write = 1'b1;
                    d.use_rs1        = 1'b1;
                    d.use_rs2        = 1'b1;
                end
                OP_J: begin
                    d.ctrl.pc_src = 1'b1;
                end
                OP_JAL: begin
                    d.ctrl.pc_src     = 1'b1;
                    d.ctrl.mem_to_reg = WB_PC4;
                    d.ctrl.reg_write  = 1'b1;
                end
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/rinsc_pipe_ctrl_scoreboard.sv
// In-flight write tracker for EX/MEM/WB; flags a read-after-write hazard on the decoding instruction.
module rinsc_scoreboard
    import rinsc_pkg::*;
#(
    parameter int NSTAGE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_vld,
    input  logic [4:0] push_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       hazard
);

    sb_entry_t sb [NSTAGE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSTAGE; i++) begin
                sb[i] <= '0;
            end
        end else begin
            for (int i = NSTAGE - 1; i > 0; i--) begin
                sb[i] <= sb[i-1];
            end
            sb[0] <= '{vld: push_vld, rd: push_rd};
        end
    end

    // r0 is compared like any other register; no special case.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (sb[i].vld && ((use_rs1 && sb[i].rd == rs1) || (use_rs2 && sb[i].rd == rs2))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rinsc_pipe_ctrl.sv
// RINSC decode-stage controller: opcode decode, RAW stall and post-jump flush.
// Hazard stalling is built only when RINSC_HAZARD_STALL_EN is defined.
module rinsc_pipe_ctrl
    import rinsc_pkg::*;
#(
    parameter int NSTAGE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Op,
    input  logic [4:0] Rs1,
    input  logic [4:0] Rs2,
    input  logic [4:0] Rd,
    output logic [3:0] ALUOp,
    output logic [1:0] ALUSrc,
    output logic [1:0] MemToReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCSrc,
    output logic       Stall,
    output logic       Flush,
    output logic       Illegal
);

    dec_t   dec;
    state_t state;
    ctrl_t  ctrl_out;
    logic   in_flush;
    logic   hazard_raw;
    logic   hazard;

    assign dec      = decode(Op);
    assign in_flush = (state == ST_FLUSH);

`ifdef RINSC_HAZARD_STALL_EN
    rinsc_scoreboard #(.NSTAGE(NSTAGE)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .push_vld (ctrl_out.reg_write),
        .push_rd  (Rd),
        .rs1      (Rs1),
        .rs2      (Rs2),
        .use_rs1  (dec.use_rs1),
        .use_rs2  (dec.use_rs2),
        .hazard   (hazard_raw)
    );
`else
    logic              unused_srcs;
    logic [NSTAGE-1:0] unused_depth;
    assign unused_srcs  = ^{Rs1, Rs2, Rd, dec.use_rs1, dec.use_rs2};
    assign unused_depth = '0;
    assign hazard_raw   = 1'b0;
`endif

    // The wrong-path slot after a jump is neither hazard-checked nor issued.
    always_comb begin
        hazard   = hazard_raw && !in_flush && !reset;
        ctrl_out = '0;
        if (!reset && !in_flush && !hazard) begin
            ctrl_out = dec.ctrl;
        end
    end

    assign ALUOp    = ctrl_out.alu_op;
    assign ALUSrc   = ctrl_out.alu_src;
    assign MemToReg = ctrl_out.mem_to_reg;
    assign MemRead  = ctrl_out.mem_read;
    assign MemWrite = ctrl_out.mem_write;
    assign RegWrite = ctrl_out.reg_write;
    assign PCSrc    = ctrl_out.pc_src;
    assign Stall    = hazard;
    assign Illegal  = dec.illegal && !in_flush && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
            Flush <= 1'b0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    state <= ST_RUN;
                    Flush <= 1'b0;
                end
                default: begin
                    if (ctrl_out.pc_src) begin
                        state <= ST_FLUSH;
                        Flush <= 1'b1;
                    end else if (hazard) begin
                        state <= ST_STALL;
                        Flush <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                        Flush <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rinsc_pipe_ctrl.sv
// Directed bench for rinsc_pipe_ctrl with a recent-writer model and a tiny register-file datapath.
module tb_rinsc_pipe_ctrl;

`ifdef RINSC_HAZARD_STALL_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif
    localparam int IMM = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Op;
    logic [4:0] Rs1, Rs2, Rd;
    logic [3:0] ALUOp;
    logic [1:0] ALUSrc, MemToReg;
    logic       MemRead, MemWrite, RegWrite, PCSrc, Stall, Flush, Illegal;

    int tests = 0;
    int fails = 0;

    rinsc_pipe_ctrl #(.NSTAGE(3)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .PCSrc(PCSrc), .Stall(Stall),
        .Flush(Flush), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] cw_now();
        return {ALUOp, ALUSrc, MemToReg, MemRead, MemWrite, RegWrite, PCSrc};
    endfunction

    // Model decode: {use_rs1, use_rs2, illegal, control word}
    function automatic logic [14:0] mdec(input logic [7:0] op);
        int o;
        o = int'(op);
        if (o >= 1 && o <= 9)         return {3'b110, 4'(o - 1),        2'd0, 2'd1, 4'b0010};
        if (o >= 'h11 && o <= 'h16)   return {3'b100, 4'(o - 'h11),     2'd1, 2'd1, 4'b0010};
        if (o >= 'h17 && o <= 'h19)   return {3'b100, 4'(o - 'h17 + 6), 2'd2, 2'd1, 4'b0010};
        case (o)
            'h00:    return 15'h0;
            'h20:    return {3'b100, 4'd0, 2'd1, 2'd0, 4'b1010};
            'h21:    return {3'b110, 4'd0, 2'd1, 2'd0, 4'b0100};
            'h30:    return {3'b000, 4'd0, 2'd0, 2'd0, 4'b0001};
            'h31:    return {3'b000, 4'd0, 2'd0, 2'd2, 4'b0011};
            default: return {3'b001, 12'h0};
        endcase
    endfunction

    // Destinations written by the last three issued instructions (-1 = none).
    int hist [3] = '{-1, -1, -1};
    bit flush_pend = 1'b0;

    function automatic bit pending(input logic [4:0] r);
        for (int i = 0; i < 3; i++) if (hist[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    int rf [32];
    bit iss_we;
    int iss_rd, iss_val;
    bit p_we [3];
    int p_rd [3];
    int p_val [3];

    always @(negedge clk) begin : model
        logic [14:0] m;
        logic [11:0] ecw;
        bit haz, infl;
        if (reset) begin
            chk("rst_ctrl", cw_now(), 0);
            chk("rst_stall", Stall, 0);
            chk("rst_flush", Flush, 0);
            chk("rst_illegal", Illegal, 0);
            for (int i = 0; i < 3; i++) hist[i] = -1;
            flush_pend = 1'b0;
        end else begin
            m    = mdec(Op);
            infl = flush_pend;
            haz  = HZ && !infl && ((m[14] && pending(Rs1)) || (m[13] && pending(Rs2)));
            ecw  = (infl || haz) ? 12'h0 : m[11:0];
            chk("ctrl", cw_now(), ecw);
            chk("stall", Stall, haz);
            chk("flush", Flush, infl);
            chk("illegal", Illegal, m[12] && !infl);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = ecw[1] ? int'(Rd) : -1;
            flush_pend = ecw[0];
        end
        iss_we  = RegWrite;
        iss_rd  = int'(Rd);
        iss_val = (ALUSrc == 2'd1) ? rf[Rs1] + IMM : rf[Rs1] + rf[Rs2];
    end

    // Datapath stand-in: write-back three edges after issue, reads at issue.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) p_we[i] = 1'b0;
        end else begin
            if (p_we[2]) rf[p_rd[2]] = p_val[2];
            for (int i = 2; i > 0; i--) begin
                p_we[i] = p_we[i-1]; p_rd[i] = p_rd[i-1]; p_val[i] = p_val[i-1];
            end
            p_we[0] = iss_we; p_rd[0] = iss_rd; p_val[0] = iss_val;
        end
    end

    task automatic drive(input logic [7:0] op, input logic [4:0] rd, rs1, rs2);
        Op = op; Rd = rd; Rs1 = rs1; Rs2 = rs2;
    endtask

    // Present one instruction until it issues; returns stall count, issued controls and Illegal.
    task automatic issue(input logic [7:0] op, input logic [4:0] rd, rs1, rs2,
                         output int stalls, output logic [11:0] cw, output logic ill);
        stalls = 0;
        drive(op, rd, rs1, rs2);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!Stall) break;
            stalls++;
            @(posedge clk); #1;
        end
        cw  = cw_now();
        ill = Illegal;
        @(posedge clk); #1;
    endtask

    task automatic nops(input int n);
        int s; logic [11:0] c; logic il;
        for (int i = 0; i < n; i++) issue(8'h00, 5'd0, 5'd0, 5'd0, s, c, il);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        logic [11:0] c;
        logic il;
        for (int i = 0; i < 32; i++) rf[i] = 100 * i;
        reset = 1'b1;
        drive(8'hFF, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        chk("reset_illegal", Illegal, 0);
        chk("reset_ctrl", cw_now(), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADDI r3 then dependent ADD r4,r3,r5
        issue(8'h11, 5'd3, 5'd0, 5'd0, s, c, il);
        chk("addi_stalls", s, 0);
        chk("addi_ctrl", c, 12'h052);
        issue(8'h01, 5'd4, 5'd3, 5'd5, s, c, il);
        chk("raw_adjacent_stalls", s, HZ ? 3 : 0);
        chk("add_ctrl", c, 12'h012);
        nops(4);
        chk("raw_adjacent_r4", rf[4], HZ ? 507 : 800);

        // ADDI r3, NOP, NOP, ADD r4,r3,r3
        issue(8'h11, 5'd3, 5'd0, 5'd0, s, c, il);
        nops(2);
        issue(8'h01, 5'd4, 5'd3, 5'd3, s, c, il);
        chk("raw_gap2_stalls", s, HZ ? 1 : 0);
        nops(4);
        chk("raw_gap2_r4", rf[4], 14);

        // Independent back-to-back ALU ops
        issue(8'h01, 5'd1, 5'd2, 5'd3, s, c, il);
        chk("indep1_stalls", s, 0);
        issue(8'h01, 5'd4, 5'd5, 5'd6, s, c, il);
        chk("indep2_stalls", s, 0);
        chk("indep2_ctrl", c, 12'h012);

        // J then a writing instruction in the wrong-path slot
        issue(8'h30, 5'd0, 5'd0, 5'd0, s, c, il);
        chk("j_ctrl", c, 12'h001);
        drive(8'h11, 5'd9, 5'd0, 5'd0);
        @(negedge clk);
        chk("j_flush", Flush, 1);
        chk("j_flush_ctrl", cw_now(), 0);
        @(posedge clk); #1;
        issue(8'h01, 5'd11, 5'd2, 5'd3, s, c, il);
        chk("j_resume_ctrl", c, 12'h012);
        nops(4);
        chk("j_wrongpath_r9", rf[9], 900);

        // JAL with an undefined opcode in the flushed slot
        issue(8'h31, 5'd31, 5'd0, 5'd0, s, c, il);
        chk("jal_ctrl", c, 12'h023);
        drive(8'hFF, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("jal_flush", Flush, 1);
        chk("flush_illegal", Illegal, 0);
        @(posedge clk); #1;

        // LW r7 then SW r7
        issue(8'h20, 5'd7, 5'd0, 5'd0, s, c, il);
        chk("lw_ctrl", c, 12'h04A);
        issue(8'h21, 5'd0, 5'd0, 5'd7, s, c, il);
        chk("lw_sw_stalls", s, HZ ? 3 : 0);
        chk("sw_ctrl", c, 12'h044);

        issue(8'h18, 5'd10, 5'd1, 5'd0, s, c, il);
        chk("srai_ctrl", c, 12'h792);

        // Undefined opcode: no write, no hazard on its Rd
        issue(8'hFF, 5'd12, 5'd0, 5'd0, s, c, il);
        chk("illegal_flag", il, 1);
        chk("illegal_ctrl", c, 0);
        issue(8'h01, 5'd13, 5'd12, 5'd12, s, c, il);
        chk("illegal_no_hazard", s, 0);
        nops(3);

        // Reset during the second stall cycle
        issue(8'h11, 5'd3, 5'd0, 5'd0, s, c, il);
        drive(8'h01, 5'd4, 5'd3, 5'd5);
        @(negedge clk);
        chk("pre_reset_stall", Stall, HZ);
        @(posedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_reset_ctrl", cw_now(), 0);
        chk("mid_reset_stall", Stall, 0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_stall", Stall, 0);
        chk("post_reset_ctrl", cw_now(), 12'h012);
        @(posedge clk); #1;
        nops(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
